iiitb_rv32i_wb_tracer: RTL and testbench

Downstream trace stage for the `iiitb_rv32i` core. It watches the core's `WB_OUT`/`PC` outputs and captures an 80-bit record on every write-back value change. Each record is `{timestamp, PC, WB_OUT}` and is buffered in a FIFO. Records are drained as a byte stream over a valid/ready handshake, so a UART or debug bridge can log core activity without hierarchical probing.

---
 rtl/iiitb_rv32i_wb_tracer_if.sv | 19 +
 rtl/iiitb_rv32i_wb_tracer.sv | 171 +++++++++++++++++
 tb/tb_iiitb_rv32i_wb_tracer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/iiitb_rv32i_wb_tracer_if.sv
// Byte-stream link from the write-back tracer to a UART or debug bridge.
// The master drives the byte and its valid flag; the slave answers with ready.
interface iiitb_rv32i_wb_tracer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/iiitb_rv32i_wb_tracer.sv
// Captures {timestamp, PC, WB_OUT} whenever the core's write-back value changes.
// Records are buffered in a FIFO and then streamed out one byte at a time, MSB first.
module iiitb_rv32i_wb_tracer #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [31:0]               PC,
    input  logic [31:0]               WB_OUT,
    iiitb_rv32i_wb_tracer_if.master   tx,
    output logic [$clog2(DEPTH):0]    count,
    output logic [7:0]                ovf_cnt,
    output logic                      busy
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned CW       = AW + 1;
    localparam int unsigned REC_W    = 80;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned LAST_IDX = 9;

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    typedef struct packed {
        logic [15:0] ts;
        logic [31:0] pc;
        logic [31:0] wb;
    } rec_t;

    // FIFO storage; it needs no reset because the pointers and count define
    // which entries are valid.
    rec_t fifo_mem [DEPTH];

    logic [15:0]      ts_q,      ts_d;
    logic [31:0]      last_wb_q, last_wb_d;
    logic             armed_q,   armed_d;
    logic [AW-1:0]    wr_ptr_q,  wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q,  rd_ptr_d;
    logic [CW-1:0]    count_q,   count_d;
    logic [7:0]       ovf_q,     ovf_d;
    state_t           state_q,   state_d;
    logic [REC_W-1:0] shreg_q,   shreg_d;
    logic [IDX_W-1:0] idx_q,     idx_d;
    logic             tx_valid_q, tx_valid_d;
    logic             busy_q,    busy_d;

    logic             push_req;
    logic             push_ok;
    logic             pop;
    logic             hs;
    rec_t             cap_rec;

    always_comb begin
        ts_d       = ts_q + 16'd1;
        last_wb_d  = last_wb_q;
        armed_d    = armed_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        state_d    = state_q;
        shreg_d    = shreg_q;
        idx_d      = idx_q;
        pop        = 1'b0;
        push_ok    = 1'b0;
        hs         = tx_valid_q && tx.tx_ready;
        cap_rec    = '{ts: ts_q, pc: PC, wb: WB_OUT};

        // A disabled edge drops the armed flag so re-enabling always captures once.
        push_req = en && (!armed_q || (WB_OUT != last_wb_q));
        if (!en) begin
            armed_d = 1'b0;
        end else if (push_req) begin
            armed_d   = 1'b1;
            last_wb_d = WB_OUT;
        end

        unique case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shreg_d = fifo_mem[rd_ptr_q];
                    idx_d   = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (hs) begin
                    if (idx_q != IDX_W'(LAST_IDX)) begin
                        idx_d   = idx_q + IDX_W'(1);
                        shreg_d = {shreg_q[REC_W-9:0], 8'h00};
                    end else if (count_q != '0) begin
                        // Chain straight into the next record with no idle cycle.
                        pop     = 1'b1;
                        shreg_d = fifo_mem[rd_ptr_q];
                        idx_d   = '0;
                    end else begin
                        shreg_d = '0;
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A pop on the same edge frees a slot, so a full FIFO still accepts.
        push_ok = push_req && ((count_q < CW'(DEPTH)) || pop);
        count_d = count_q + CW'(push_ok) - CW'(pop);

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_req && !push_ok && (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 8'd1;
        end

        tx_valid_d = (state_d == S_SEND);
        busy_d     = (state_d == S_SEND);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q       <= '0;
            last_wb_q  <= '0;
            armed_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= '0;
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            idx_q      <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            last_wb_q  <= last_wb_d;
            armed_q    <= armed_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            idx_q      <= idx_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= cap_rec;
        end
    end

    assign tx.tx_data  = shreg_q[REC_W-1 -: 8];
    assign tx.tx_valid = tx_valid_q;
    assign count       = count_q;
    assign ovf_cnt     = ovf_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_iiitb_rv32i_wb_tracer.sv
// Directed bench for the write-back tracer: single record, back-pressure,
// overflow, saturation, reset mid-frame, re-arm and timestamp wrap.
module tb_iiitb_rv32i_wb_tracer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [31:0] pc  = '0;
    logic [31:0] wb  = '0;
    logic [4:0]  count;
    logic [7:0]  ovf_cnt;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    iiitb_rv32i_wb_tracer_if tx_if ();

    iiitb_rv32i_wb_tracer #(.DEPTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .PC      (pc),
        .WB_OUT  (wb),
        .tx      (tx_if),
        .count   (count),
        .ovf_cnt (ovf_cnt),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Edge counter since reset release; its value before an edge is that edge's stamp.
    logic [15:0] cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= '0;
        else     cyc <= cyc + 16'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; waits for a handshake-ready byte, checks it, moves past the handshake.
    task automatic expect_byte(input logic [7:0] exp, input string tag, output int waited);
        waited = 0;
        while (!(tx_if.tx_valid === 1'b1 && tx_if.tx_ready === 1'b1) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        assert (tx_if.tx_valid === 1'b1 && tx_if.tx_data === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h (valid %b) required %h", tag, tx_if.tx_data, tx_if.tx_valid, exp);
        end
        @(negedge clk);
    endtask

    task automatic expect_rec(input logic [79:0] rec, input int first, input int last,
                              input string tag, output int first_wait);
        int w;
        first_wait = 0;
        for (int b = first; b <= last; b++) begin
            expect_byte(rec[79-8*b -: 8], $sformatf("%s_b%0d", tag, b), w);
            if (b == first) first_wait = w;
            else chk($sformatf("%s_gap%0d", tag, b), 32'(w), 32'd0);
        end
    endtask

    task automatic reset_hold();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int          w;
        int          guard;
        logic [15:0] t;
        logic [79:0] rec;

        tx_if.tx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_tx_valid", 32'(tx_if.tx_valid), 32'd0);
        chk("rst_tx_data",  32'(tx_if.tx_data),  32'd0);
        chk("rst_count",    32'(count),          32'd0);
        chk("rst_ovf",      32'(ovf_cnt),        32'd0);
        chk("rst_busy",     32'(busy),           32'd0);

        // Single record: bytes 00 00 00 00 00 04 00 00 00 03.
        en = 1'b1; pc = 32'h0000_0004; wb = 32'h0000_0003; rst = 1'b0;
        expect_rec({16'h0000, 32'h0000_0004, 32'h0000_0003}, 0, 9, "single", w);
        chk("single_latency", 32'(w), 32'd2);
        chk("single_idle_valid", 32'(tx_if.tx_valid), 32'd0);
        chk("single_idle_busy",  32'(busy),           32'd0);
        chk("single_idle_count", 32'(count),          32'd0);
        repeat (5) @(negedge clk);
        chk("single_quiet_valid", 32'(tx_if.tx_valid), 32'd0);
        chk("single_quiet_count", 32'(count),          32'd0);

        // Back-pressure after byte 3 for 5 cycles.
        t = cyc; pc = 32'h0000_0008; wb = 32'h0000_0055;
        rec = {t, 32'h0000_0008, 32'h0000_0055};
        expect_rec(rec, 0, 3, "bp", w);
        tx_if.tx_ready = 1'b0;
        repeat (5) begin
            chk("bp_valid", 32'(tx_if.tx_valid), 32'd1);
            chk("bp_hold",  32'(tx_if.tx_data),  32'(rec[47:40]));
            @(negedge clk);
        end
        tx_if.tx_ready = 1'b1;
        expect_rec(rec, 4, 9, "bp_resume", w);
        chk("bp_resume_wait", 32'(w), 32'd0);

        // Overflow: 20 changing samples with the sink stalled.
        reset_hold();
        tx_if.tx_ready = 1'b0; en = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            pc = 32'h0000_1000 + 32'(4 * i);
            wb = 32'(i);
            if (i == 1) rst = 1'b0;
            @(negedge clk);
        end
        chk("ovf_count", 32'(count),          32'd16);
        chk("ovf_busy",  32'(busy),           32'd1);
        chk("ovf_cnt",   32'(ovf_cnt),        32'd3);
        chk("ovf_valid", 32'(tx_if.tx_valid), 32'd1);
        tx_if.tx_ready = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            expect_rec({16'(k - 1), 32'h0000_1000 + 32'(4 * k), 32'(k)}, 0, 9,
                       $sformatf("ovf_r%0d", k), w);
            if (k > 1) chk($sformatf("ovf_r%0d_bubble", k), 32'(w), 32'd0);
        end
        chk("ovf_drain_count", 32'(count),   32'd0);
        chk("ovf_drain_busy",  32'(busy),    32'd0);
        chk("ovf_drain_cnt",   32'(ovf_cnt), 32'd3);

        // Saturation: 300 drops beyond a full FIFO plus serializer.
        reset_hold();
        tx_if.tx_ready = 1'b0; en = 1'b1;
        for (int i = 1; i <= 317; i++) begin
            pc = 32'h0000_1000 + 32'(4 * i);
            wb = 32'(i);
            if (i == 1) rst = 1'b0;
            @(negedge clk);
            if (i == 271) chk("sat_254", 32'(ovf_cnt), 32'd254);
        end
        chk("sat_255",   32'(ovf_cnt), 32'd255);
        chk("sat_count", 32'(count),   32'd16);

        // Reset mid-frame after byte 3.
        tx_if.tx_ready = 1'b1;
        expect_rec({16'h0000, 32'h0000_1004, 32'h0000_0001}, 0, 3, "mid", w);
        #2 rst = 1'b1;
        #1;
        chk("mid_valid",   32'(tx_if.tx_valid), 32'd0);
        chk("mid_count",   32'(count),          32'd0);
        chk("mid_busy",    32'(busy),           32'd0);
        chk("mid_ovf",     32'(ovf_cnt),        32'd0);
        chk("mid_tx_data", 32'(tx_if.tx_data),  32'd0);
        @(negedge clk);
        en = 1'b0; pc = 32'h0000_2000; wb = 32'h0000_0077; rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            chk("mid_quiet", 32'(tx_if.tx_valid), 32'd0);
        end

        // Re-arm: one record per enable with constant WB_OUT.
        t = cyc; en = 1'b1;
        expect_rec({t, 32'h0000_2000, 32'h0000_0077}, 0, 9, "arm1", w);
        repeat (5) @(negedge clk);
        chk("arm1_count", 32'(count),          32'd0);
        chk("arm1_valid", 32'(tx_if.tx_valid), 32'd0);
        en = 1'b0;
        repeat (2) @(negedge clk);
        t = cyc; en = 1'b1;
        expect_rec({t, 32'h0000_2000, 32'h0000_0077}, 0, 9, "arm2", w);
        repeat (5) @(negedge clk);
        chk("arm2_count", 32'(count),          32'd0);
        chk("arm2_valid", 32'(tx_if.tx_valid), 32'd0);

        // Timestamp wrap: captures stamped 0xFFFF then 0x0000.
        guard = 0;
        while (cyc !== 16'hFFFF && guard < 70000) begin
            @(negedge clk);
            guard++;
        end
        chk("wrap_wait_bound", 32'(guard < 70000), 32'd1);
        pc = 32'h0000_3000; wb = 32'h0000_00A1;
        @(negedge clk);
        pc = 32'h0000_3004; wb = 32'h0000_00A2;
        expect_rec({16'hFFFF, 32'h0000_3000, 32'h0000_00A1}, 0, 9, "wrap1", w);
        expect_rec({16'h0000, 32'h0000_3004, 32'h0000_00A2}, 0, 9, "wrap2", w);
        chk("wrap2_bubble", 32'(w), 32'd0);
        repeat (3) @(negedge clk);
        chk("wrap_end_count", 32'(count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
